// File: rtl/dii_package.sv
// Debug-interconnect flit type shared by every block that drives or sinks
// command flits.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/noc_control_pkg.sv
// Command-flit field layout, queued-command record and FSM encoding shared by
// the command generator and the command decoder.
package noc_control_pkg;

  localparam int SEL_LSB     = 0;
  localparam int SEL_W       = 4;
  localparam int DATA_LSB    = 4;
  localparam int DATA_W      = 4;
  localparam int SLOT_LSB    = 8;
  localparam int SLOT_W      = 8;
  localparam int NI_SEL_BIT  = 15;
  localparam int LINK_EN_BIT = 14;
  localparam int NODE_LSB    = 0;
  localparam int NODE_W      = 14;

  // Fields are stored at their full flit width so the FIFO never depends on
  // mesh or port-count parameters.
  typedef struct packed {
    logic              ni_sel;
    logic              link_en;
    logic [NODE_W-1:0] node;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
    logic [SLOT_W-1:0] slot;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  function automatic logic [15:0] first_flit_data(input cmd_t c);
    logic [15:0] d;
    d = '0;
    d[SEL_LSB +: SEL_W]   = c.sel;
    d[DATA_LSB +: DATA_W] = c.data;
    d[SLOT_LSB +: SLOT_W] = c.slot;
    return d;
  endfunction

  function automatic logic [15:0] second_flit_data(input cmd_t c);
    logic [15:0] d;
    d = '0;
    d[NI_SEL_BIT]         = c.ni_sel;
    d[LINK_EN_BIT]        = c.link_en;
    d[NODE_LSB +: NODE_W] = c.node;
    return d;
  endfunction

endpackage

// File: rtl/noc_control_module_lut_cmd_gen_if.sv
// Request handshake plus outgoing flit stream of the LUT command generator.
// The master side issues requests and sinks flits; the slave side is the generator.
interface noc_control_module_lut_cmd_gen_if #(
  parameter int NODE_W = 4,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 3,
  parameter int SLOT_W = 3
);

  logic                    req_valid;
  logic                    req_ready;
  logic [NODE_W-1:0]       req_node;
  logic                    req_ni_sel;
  logic                    req_link_en;
  logic [SEL_W-1:0]        req_sel;
  logic [DATA_W-1:0]       req_data;
  logic [SLOT_W-1:0]       req_slot;
  dii_package::dii_flit    flit_out;
  logic                    flit_out_ready;

  modport master (
    output req_valid, req_node, req_ni_sel, req_link_en,
           req_sel, req_data, req_slot, flit_out_ready,
    input  req_ready, flit_out
  );

  modport slave (
    input  req_valid, req_node, req_ni_sel, req_link_en,
           req_sel, req_data, req_slot, flit_out_ready,
    output req_ready, flit_out
  );

endinterface

// File: rtl/noc_control_cmd_fifo.sv
// Synchronous command FIFO; the head entry is visible combinationally so the
// flit stream can be formed without an extra read cycle.
module noc_control_cmd_fifo
  import noc_control_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  cmd_t          wr_cmd,
  input  logic          pop,
  output cmd_t          rd_cmd,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_cmd;
  end

  assign rd_cmd = mem[rd_ptr_reg];
  assign full   = (count_reg == CW'(DEPTH));
  assign empty  = (count_reg == '0);
  assign count  = count_reg;

endmodule

// File: rtl/noc_control_module_lut_cmd_gen.sv
// Queues router/NI slot-table and link-enable commands and serialises each
// one into a two-flit command on the debug interconnect.
module noc_control_module_lut_cmd_gen
  import noc_control_pkg::*;
#(
  parameter int X          = 3,
  parameter int Y          = 3,
  parameter int LUT_SIZE   = 8,
  parameter int MAX_PORTS  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  noc_control_module_lut_cmd_gen_if.slave  bus,
  output logic                             busy,
  output logic [15:0]                      cmd_count
);

  localparam int NODES   = X * Y;
  localparam int NODE_IW = $clog2(NODES);
  localparam int SEL_IW  = $clog2(MAX_PORTS);
  localparam int DATA_IW = $clog2(MAX_PORTS + 1);
  localparam int SLOT_IW = $clog2(LUT_SIZE);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  state_t        state_reg;
  state_t        state_next;
  logic          ready_en_reg;
  logic [15:0]   cmd_count_reg;
  cmd_t          wr_cmd;
  cmd_t          head_cmd;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic          flit_fire;
  logic          more_after_pop;

  always_comb begin
    wr_cmd         = '0;
    wr_cmd.node    = NODE_W'(bus.req_node[NODE_IW-1:0]);
    wr_cmd.sel     = SEL_W'(bus.req_sel[SEL_IW-1:0]);
    wr_cmd.data    = DATA_W'(bus.req_data[DATA_IW-1:0]);
    wr_cmd.slot    = SLOT_W'(bus.req_slot[SLOT_IW-1:0]);
    wr_cmd.ni_sel  = bus.req_ni_sel;
    wr_cmd.link_en = bus.req_link_en;
  end

  // req_ready stays low through reset and rises on the first edge after it.
  assign bus.req_ready  = ready_en_reg && !fifo_full;
  assign push           = bus.req_valid && bus.req_ready;
  assign flit_fire      = bus.flit_out.valid && bus.flit_out_ready;
  assign pop            = (state_reg == SECOND) && flit_fire;
  assign more_after_pop = (fifo_count > CW'(1)) || push;
  assign busy           = !fifo_empty || (state_reg != IDLE);
  assign cmd_count      = cmd_count_reg;

  noc_control_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_cmd (wr_cmd),
    .pop    (pop),
    .rd_cmd (head_cmd),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_reg  <= 1'b0;
      cmd_count_reg <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      if (pop) cmd_count_reg <= cmd_count_reg + 16'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!fifo_empty) state_next = FIRST;
      FIRST:   if (flit_fire) state_next = SECOND;
      SECOND:  if (flit_fire) state_next = more_after_pop ? FIRST : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The head entry is only popped after its second flit, so both flits are
  // derived from a stable source and hold while backpressured.
  always_comb begin
    bus.flit_out = '0;
    case (state_reg)
      FIRST: begin
        bus.flit_out.valid = 1'b1;
        bus.flit_out.last  = 1'b0;
        bus.flit_out.data  = first_flit_data(head_cmd);
      end
      SECOND: begin
        bus.flit_out.valid = 1'b1;
        bus.flit_out.last  = 1'b1;
        bus.flit_out.data  = second_flit_data(head_cmd);
      end
      default: bus.flit_out = '0;
    endcase
  end

endmodule

// File: tb/tb_noc_control_module_lut_cmd_gen.sv
// Self-checking bench for the LUT command generator: vector table, directed
// backpressure/full/reset sequences and a randomized run against a decoder model.
module tb_noc_control_module_lut_cmd_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] cmd_count;

  always #5 clk = ~clk;

  noc_control_module_lut_cmd_gen_if #(
    .NODE_W (4), .SEL_W (3), .DATA_W (3), .SLOT_W (3)
  ) bus ();

  noc_control_module_lut_cmd_gen #(
    .X (3), .Y (3), .LUT_SIZE (8), .MAX_PORTS (6), .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .cmd_count (cmd_count)
  );

  typedef struct {
    int node;
    int sel;
    int data;
    int slot;
    int ni;
    int link;
  } cmd_rec_t;

  typedef struct {
    cmd_rec_t c;
    int       f1;
    int       f2;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  cmd_rec_t    exp_q[$];
  int          done_cnt = 0;
  bit          have_first = 0;
  int          first_word = 0;
  bit          prev_pending = 0;
  logic [16:0] prev_flit = '0;
  vec_t        vecs[5];
  cmd_rec_t    cr;
  logic [15:0] fd;
  logic        fl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int enc1(input cmd_rec_t c);
    return c.slot * 256 + c.data * 16 + c.sel;
  endfunction

  function automatic int enc2(input cmd_rec_t c);
    return c.ni * 32768 + c.link * 16384 + c.node;
  endfunction

  function automatic int strobe_of(input int ni, input int link);
    return (link != 0) ? 2 : ((ni != 0) ? 1 : 0);
  endfunction

  // Behavioural decoder: rebuilds commands from accepted flit pairs.
  always @(negedge clk) begin
    if (rst) begin
      have_first   = 0;
      prev_pending = 0;
      done_cnt     = 0;
    end else begin
      if (bus.req_valid && bus.req_ready)
        exp_q.push_back('{int'(bus.req_node), int'(bus.req_sel), int'(bus.req_data),
                          int'(bus.req_slot), int'(bus.req_ni_sel), int'(bus.req_link_en)});
      if (prev_pending)
        chk("hold_stable", {bus.flit_out.valid, bus.flit_out.last, bus.flit_out.data},
            {1'b1, prev_flit});
      prev_pending = bus.flit_out.valid && !bus.flit_out_ready;
      prev_flit    = {bus.flit_out.last, bus.flit_out.data};
      if (bus.flit_out.valid && bus.flit_out_ready) begin
        if (!bus.flit_out.last) begin
          chk("no_interleave", 32'(have_first), 32'd0);
          have_first = 1;
          first_word = int'(bus.flit_out.data);
        end else begin
          int w2;
          cmd_rec_t e;
          w2 = int'(bus.flit_out.data);
          chk("second_has_first", 32'(have_first), 32'd1);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_cmd: got word 0x%0h, expected no command", w2);
          end else begin
            e = exp_q.pop_front();
            chk("dec_node", w2 % 16384, e.node);
            chk("dec_sel", first_word % 16, e.sel);
            chk("dec_data", (first_word / 16) % 16, e.data);
            chk("dec_slot", first_word / 256, e.slot);
            chk("dec_ni", w2 / 32768, e.ni);
            chk("dec_link", (w2 / 16384) % 2, e.link);
            chk("dec_strobe", strobe_of(w2 / 32768, (w2 / 16384) % 2), strobe_of(e.ni, e.link));
            $display("[TB] cmd node=%0d sel=%0d data=%0d slot=%0d ni=%0d link=%0d",
                     w2 % 16384, first_word % 16, (first_word / 16) % 16,
                     first_word / 256, w2 / 32768, (w2 / 16384) % 2);
          end
          done_cnt++;
          have_first = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input cmd_rec_t c);
    bit done;
    done            = 0;
    bus.req_node    = 4'(c.node);
    bus.req_sel     = 3'(c.sel);
    bus.req_data    = 3'(c.data);
    bus.req_slot    = 3'(c.slot);
    bus.req_ni_sel  = 1'(c.ni);
    bus.req_link_en = 1'(c.link);
    bus.req_valid   = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: req_ready stayed 0, expected 1");
    end
  endtask

  task automatic wait_flit(output logic [15:0] d, output logic l);
    bit got;
    got = 0;
    d   = '0;
    l   = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.flit_out.valid && bus.flit_out_ready) begin
        got = 1;
        d   = bus.flit_out.data;
        l   = bus.flit_out.last;
      end
      tick();
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL flit_timeout: no flit accepted, expected one");
    end
  endtask

  task automatic wait_valid();
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.flit_out.valid) got = 1;
      else tick();
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL valid_timeout: flit_out.valid stayed 0, expected 1");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{'{5, 2, 3, 7, 0, 0}, 'h0732, 'h0005};
    vecs[1] = '{'{8, 1, 1, 1, 1, 1}, 'h0111, 'hC008};
    vecs[2] = '{'{3, 4, 5, 2, 1, 0}, 'h0254, 'h8003};
    vecs[3] = '{'{0, 5, 6, 0, 0, 1}, 'h0065, 'h4000};
    vecs[4] = '{'{8, 5, 6, 7, 0, 0}, 'h0765, 'h0008};

    bus.req_valid      = 1'b0;
    bus.req_node       = '0;
    bus.req_sel        = '0;
    bus.req_data       = '0;
    bus.req_slot       = '0;
    bus.req_ni_sel     = 1'b0;
    bus.req_link_en    = 1'b0;
    bus.flit_out_ready = 1'b1;

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_valid", 32'(bus.flit_out.valid), 32'd0);
    chk("rst_last", 32'(bus.flit_out.last), 32'd0);
    chk("rst_data", 32'(bus.flit_out.data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(cmd_count), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", 32'(bus.req_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("ready_after_edge", 32'(bus.req_ready), 32'd1);
    tick();

    // Vector table: single commands with ready held high
    for (int v = 0; v < 5; v++) begin
      push_cmd(vecs[v].c);
      wait_flit(fd, fl);
      chk("vec_first_data", 32'(fd), 32'(vecs[v].f1));
      chk("vec_first_last", 32'(fl), 32'd0);
      wait_flit(fd, fl);
      chk("vec_second_data", 32'(fd), 32'(vecs[v].f2));
      chk("vec_second_last", 32'(fl), 32'd1);
    end
    @(negedge clk);
    chk("vec_count", 32'(cmd_count), 32'd5);
    tick();

    // Backpressure on the first flit for 5 cycles
    bus.flit_out_ready = 1'b0;
    push_cmd(vecs[0].c);
    wait_valid();
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.flit_out.valid), 32'd1);
      chk("hold_data", 32'(bus.flit_out.data), 32'h0732);
      chk("hold_last", 32'(bus.flit_out.last), 32'd0);
      tick();
    end
    bus.flit_out_ready = 1'b1;
    wait_flit(fd, fl);
    chk("hold_first", 32'(fd), 32'h0732);
    wait_flit(fd, fl);
    chk("hold_second", 32'(fd), 32'h0005);
    @(negedge clk);
    chk("hold_count", 32'(cmd_count), 32'd6);
    tick();

    // Fill the FIFO, then drain back-to-back
    bus.flit_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.req_node    = 4'(i + 1);
      bus.req_sel     = 3'(i);
      bus.req_data    = 3'(i + 1);
      bus.req_slot    = 3'(i + 2);
      bus.req_ni_sel  = 1'b0;
      bus.req_link_en = 1'(i % 2);
      bus.req_valid   = 1'b1;
      @(negedge clk);
      chk("full_req_ready", 32'(bus.req_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("full_ready_low", 32'(bus.req_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    tick();
    bus.flit_out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      cr = '{j / 2 + 1, j / 2, j / 2 + 1, j / 2 + 2, 0, (j / 2) % 2};
      @(negedge clk);
      chk("b2b_valid", 32'(bus.flit_out.valid), 32'd1);
      chk("b2b_data", 32'(bus.flit_out.data), 32'((j % 2 == 0) ? enc1(cr) : enc2(cr)));
      chk("b2b_last", 32'(bus.flit_out.last), 32'(j % 2));
      tick();
    end
    @(negedge clk);
    chk("b2b_count", 32'(cmd_count), 32'd10);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    tick();

    // Reset while in SECOND with two queued commands
    bus.flit_out_ready = 1'b0;
    push_cmd('{1, 1, 2, 3, 0, 0});
    push_cmd('{2, 3, 4, 5, 1, 0});
    wait_valid();
    tick();
    bus.flit_out_ready = 1'b1;
    @(negedge clk);
    tick();
    bus.flit_out_ready = 1'b0;
    @(negedge clk);
    chk("mid_in_second", 32'(bus.flit_out.last), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.flit_out.valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(cmd_count), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    bus.flit_out_ready = 1'b1;
    cr = '{7, 4, 2, 6, 0, 1};
    push_cmd(cr);
    wait_flit(fd, fl);
    chk("post_rst_first", 32'(fd), 32'(enc1(cr)));
    chk("post_rst_first_last", 32'(fl), 32'd0);
    wait_flit(fd, fl);
    chk("post_rst_second", 32'(fd), 32'(enc2(cr)));
    @(negedge clk);
    chk("post_rst_count", 32'(cmd_count), 32'd1);
    tick();

    // Randomized request/ready stress, checked by the decoder model
    for (int n = 0; n < 400; n++) begin
      bus.req_valid      = 1'($urandom_range(0, 1));
      bus.req_node       = 4'($urandom_range(0, 8));
      bus.req_sel        = 3'($urandom_range(0, 5));
      bus.req_data       = 3'($urandom_range(0, 6));
      bus.req_slot       = 3'($urandom_range(0, 7));
      bus.req_ni_sel     = 1'($urandom_range(0, 1));
      bus.req_link_en    = 1'($urandom_range(0, 1));
      bus.flit_out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.req_valid      = 1'b0;
    bus.flit_out_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() > 0 || have_first); i++) tick();
    tick();
    tick();
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_count", 32'(cmd_count), 32'(done_cnt % 65536));
    chk("drain_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noc_control_module_lut_cmd_gen.md
NOC_CONTROL_MODULE_LUT_CMD_GEN -- requirements
Module: noc_control_module_lut_cmd_gen

Interface
REQ-001 SHALL have parameter X, default 3, mesh width.
REQ-002 SHALL have parameter Y, default 3, mesh height; localparam NODES = X*Y.
REQ-003 SHALL have parameter LUT_SIZE, default 8, slot-table entries.
REQ-004 SHALL have parameter MAX_PORTS, default 6, router/NI ports.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, queued commands (power of two, >=2).
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port req_valid / req_ready, input / output, 1 each, command handshake.
REQ-009 SHALL have port req_node, input, $clog2(NODES), target router/NI.
REQ-010 SHALL have port req_ni_sel, input, 1, set to configure the NI slot table.
REQ-011 SHALL have port req_link_en, input, 1, set for a link enable/disable command.
REQ-012 SHALL have port req_sel, input, $clog2(MAX_PORTS), output port or endpoint.
REQ-013 SHALL have port req_data, input, $clog2(MAX_PORTS+1), forward port or enable value.
REQ-014 SHALL have port req_slot, input, $clog2(LUT_SIZE), slot or link index.
REQ-015 SHALL have port flit_out, output, dii_flit, command flit stream.
REQ-016 SHALL have port flit_out_ready, input, 1, downstream accepts the flit.
REQ-017 SHALL have port busy, output, 1, FIFO non-empty or FSM not IDLE.
REQ-018 SHALL have port cmd_count, output, 16, completed commands (wraps).

Function
REQ-019 SHALL push the request into the FIFO when req_valid && req_ready; req_ready = FIFO not full. A pop in the same cycle does not raise req_ready.
REQ-020 SHALL emit each command as two flits. First flit: data[3:0]=sel, [7:4]=data, [15:8]=slot, last=0. Second flit: data[15]=ni_sel, [14]=link_en, [13:0]=node, last=1. Narrower fields SHALL be zero-extended.
REQ-021 SHALL transmit ni_sel and link_en verbatim, including when both are 1; the receiver gives link_en priority.
REQ-022 SHALL implement FSM states IDLE, FIRST, SECOND.
  - IDLE->FIRST when the FIFO is non-empty.
  - FIRST->SECOND on flit_out.valid && flit_out_ready.
  - SECOND->FIRST on acceptance if another entry remains after the pop, else SECOND->IDLE.
REQ-023 SHALL drive flit_out.valid=1 only in FIRST/SECOND. Once asserted, valid and data SHALL stay stable until accepted.
REQ-024 SHALL pop the FIFO head and increment cmd_count (mod 2^16) on acceptance of the second flit.
REQ-025 SHALL present the first flit no earlier than one cycle after the request is accepted into an empty FIFO.
REQ-026 SHALL, with flit_out_ready held high, emit queued commands back-to-back at one flit per cycle with no idle cycles.
REQ-027 SHALL never interleave flits of different commands, and never emit a second flit without its first.

Reset
REQ-028 SHALL asynchronously clear on rst=1: FSM=IDLE, FIFO empty, cmd_count=0, flit_out.valid=0, flit_out.last=0, flit_out.data=0, busy=0, req_ready=0.
REQ-029 SHALL, on reset mid-command, discard the partial command; after release the next flit is a first flit of a newly accepted command.
REQ-030 SHALL assert req_ready=1 from the first clock edge after rst deasserts.

Structure
REQ-031 SHALL take dii_flit from dii_package. Flit field bit positions (SEL, DATA, SLOT, NI_SEL=15, LINK_EN=14, NODE=13:0) SHALL be localparams in a shared noc_control_pkg, used by both this block and the command decoder.
REQ-032 SHALL instantiate one sub-module, noc_control_cmd_fifo: a synchronous FIFO with full/empty flags and async reset, holding a packed command struct defined in noc_control_pkg.

Verification
REQ-033 Single command, node=5, sel=2, data=3, slot=7, ni_sel=0, link_en=0, ready=1 -> flit 0x0732 last=0, then 0x0005 last=1; cmd_count=1.
REQ-034 ready=0 for 5 cycles after first flit -> valid=1 and data 0x0732 stable all 5 cycles; no FSM advance.
REQ-035 Push 5 commands with ready=0 (depth 4) -> req_ready=0 after the 4th push; with ready=1, 8 consecutive flits in order; cmd_count=4.
REQ-036 link_en=1, ni_sel=1, node=8 -> second flit 0xC008; ni_sel=1 only, node=3 -> 0x8003.
REQ-037 Assert rst while in SECOND with 2 queued commands -> valid=0 immediately; busy=0; cmd_count=0; next command starts with a first flit.
REQ-038 Random req/ready stress with a behavioural copy of the decoder -> every decoded (node, sel, data, slot, strobe) matches the issued sequence exactly.
